aes_pipe_sched: RTL and testbench
=================================

Name: aes_pipe_sched

Overview:
Scheduler that shares the single non-stallable pipelined AES datapath between two block requesters (port 0, port 1). Arbitrates one 128-bit block per cycle into the pipeline input (valid/type/data) and tags each issued block. Routes each pipeline result back to the owning requester through a per-port response FIFO. Issue is credit-gated so a result always has FIFO space on arrival. Sits between the host/mode front-ends and the round pipeline plus its control-delay pipeline.

Parameters:
LAT, 10, pipeline latency in cycles from p_vin sampled to matching p_vout asserted
DEPTH, 16, entries per response FIFO; power of two, >= LAT+2 for full single-port throughput
AW, 4, log2(DEPTH)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
r0_valid  in  1  port 0 block request
r0_ready  out  1  port 0 request accepted this cycle (combinational grant)
r0_type  in  1  port 0 type bit (1 = encrypt, 0 = decrypt)
r0_data  in  128  port 0 block
r1_valid, r1_ready, r1_type, r1_data  same as port 0, for port 1
p_vin  out  1  pipeline input valid (registered)
p_tin  out  1  pipeline input type (registered)
p_din  out  128  pipeline input data (registered)
p_vout  in  1  pipeline output valid
p_tout  in  1  pipeline output type
p_dout  in  128  pipeline output data
q0_valid  out  1  port 0 result available (FIFO not empty)
q0_ready  in  1  port 0 result consumed when q0_valid & q0_ready
q0_type  out  1  type of head result
q0_data  out  128  head result
q1_valid, q1_ready, q1_type, q1_data  same as port 0, for port 1
err  out  1  sticky tag/pipeline mismatch flag

Behaviour:
- Reset (rst_n low, async): p_vin/p_tin/p_din=0, q*_valid=0, q*_type/q*_data=0, err=0, FIFOs empty, inflight counters=0, tag shift register cleared, rr pointer=0. Reset mid-operation discards all in-flight blocks; the pipeline is reset by the same rst_n at the top level.
- Credit: credit_i = DEPTH - count_i - inflight_i. Port i is eligible when ri_valid & credit_i>0.
- Arbitration: round-robin. Both eligible -> grant port rr; single eligible -> grant it. On any grant, rr <= ~granted port. ri_ready = grant_i; at most one grant per cycle. ri_ready never asserts without ri_valid.
- Issue: on grant at edge t, p_vin=1, p_tin/p_din=granted type/data from t+1; with no grant, p_vin=0 and p_tin/p_din hold.
- Tag shift register: LAT+1 entries {v,id}. Entry 0 loads {grant, granted id} on the issue edge; shifts every cycle. The tag at entry LAT aligns with p_vout.
- Inflight_i: +1 on issue to i, -1 on FIFO write to i; simultaneous -> unchanged. Width AW+1.
- Retire: when p_vout=1 and the aligned tag v=1, write {p_tout,p_dout} to FIFO[id] on that edge.
- Mismatch: p_vout != aligned tag v sets err (sticky until reset). An untagged p_vout is dropped. A tagged slot without p_vout decrements inflight and writes nothing.
- Latency: accept edge -> q_valid high LAT+2 cycles later, with an empty FIFO.
- FIFO: q_data/q_type show the head combinationally. Simultaneous read and write leaves count unchanged. A full FIFO cannot be written (credit guarantees this). Pointers wrap modulo DEPTH.
- Throughput: 1 block/cycle aggregate. A single port with q_ready held high sustains 1/cycle when DEPTH >= LAT+2.

Decomposition:
- Shared package aes_sched_pkg: constants BLK_W=128, PORTS=2, default LAT=10, type encodings ENC=1/DEC=0.
- One sub-module: sched_resp_fifo (DEPTH x 129-bit synchronous FIFO, with count output feeding the credit calculation), instantiated twice.

Test Plan:
- Reset: hold rst_n low mid-stream with 5 blocks in flight -> all outputs 0 immediately, q0_valid=q1_valid=0 after release, err=0.
- Single port streaming: r0_valid held high, 20 blocks data=i, type=1, q0_ready=1 -> r0_ready high every cycle; q0_data sequence 0..19 (loopback pipeline model with LAT=10); first q0_valid 12 cycles after first accept.
- Contention: both ports valid continuously -> grants alternate 0,1,0,1 starting with port 0 after reset; each port's results return in order to its own q port.
- Backpressure: q1_ready=0, r1 streaming -> exactly 16 blocks accepted, r1_ready then stays low. Raising q1_ready for 1 cycle -> exactly one more accept. Port 0 remains unaffected.
- Simultaneous FIFO read/write: FIFO0 holding 3 entries, q0_ready=1 during a retire to port 0 -> count stays 3 and order is preserved.
- Mismatch: inject p_vout=1 with no issued tag -> err=1 the next cycle, stays 1, no FIFO write occurs.

Source files
------------

// File: rtl/aes_sched_pkg.sv
// Shared constants and payload types for the AES pipeline scheduler.
package aes_sched_pkg;

  localparam int unsigned BLK_W       = 128;
  localparam int unsigned PORTS       = 2;
  localparam int unsigned LAT_DEFAULT = 10;
  localparam logic        ENC         = 1'b1;
  localparam logic        DEC         = 1'b0;

  // One block as it travels through a response FIFO.
  typedef struct packed {
    logic             typ;
    logic [BLK_W-1:0] data;
  } blk_t;

  // Ownership tag riding alongside a block in the round pipeline.
  typedef struct packed {
    logic v;
    logic id;
  } tag_t;

endpackage

// File: rtl/sched_resp_fifo.sv
// Per-port response FIFO; head is shown combinationally, count feeds issue credit.
module sched_resp_fifo
  import aes_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr,
  input  blk_t        wdata,
  input  logic        ready,
  output logic        valid,
  output blk_t        rdata,
  output logic [AW:0] count
);

  blk_t          mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_wr;
  logic          do_rd;

  assign valid = (count != '0);
  assign do_rd = ready && valid;
  assign do_wr = wr && (count != (AW+1)'(DEPTH));
  assign rdata = valid ? mem[rp] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_wr) wp <= wp + AW'(1);
      if (do_rd) rp <= rp + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wp] <= wdata;
  end

endmodule

// File: rtl/aes_pipe_sched.sv
// Shares one non-stallable AES pipeline between two requesters: credit-gated
// round-robin issue, tag tracking through the pipeline, per-port result FIFOs.
module aes_pipe_sched
  import aes_sched_pkg::*;
#(
  parameter int unsigned LAT   = LAT_DEFAULT,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic             r0_type,
  input  logic [BLK_W-1:0] r0_data,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic             r1_type,
  input  logic [BLK_W-1:0] r1_data,
  output logic             p_vin,
  output logic             p_tin,
  output logic [BLK_W-1:0] p_din,
  input  logic             p_vout,
  input  logic             p_tout,
  input  logic [BLK_W-1:0] p_dout,
  output logic             q0_valid,
  input  logic             q0_ready,
  output logic             q0_type,
  output logic [BLK_W-1:0] q0_data,
  output logic             q1_valid,
  input  logic             q1_ready,
  output logic             q1_type,
  output logic [BLK_W-1:0] q1_data,
  output logic             err
);

  localparam int unsigned CW = AW + 2;

  blk_t             req  [PORTS];
  blk_t             head [PORTS];
  logic [AW:0]      cnt  [PORTS];
  logic [AW:0]      infl [PORTS];
  tag_t             tag  [LAT+1];
  tag_t             aligned;
  blk_t             res;
  logic [PORTS-1:0] vld;
  logic [PORTS-1:0] elig;
  logic [PORTS-1:0] gnt;
  logic [PORTS-1:0] dec;
  logic [PORTS-1:0] wr;
  logic [PORTS-1:0] qv;
  logic [PORTS-1:0] qr;
  logic             rr;

  assign vld    = {r1_valid, r0_valid};
  assign qr     = {q1_ready, q0_ready};
  assign req[0] = '{typ: r0_type, data: r0_data};
  assign req[1] = '{typ: r1_type, data: r1_data};
  assign res    = '{typ: p_tout, data: p_dout};

  // A port may issue only while its FIFO can absorb every block it has in flight.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      elig[i] = vld[i] && ((CW'(cnt[i]) + CW'(infl[i])) < CW'(DEPTH));
    end
  end

  always_comb begin
    gnt = '0;
    if (elig[0] && (!elig[1] || !rr)) gnt[0] = 1'b1;
    else if (elig[1])                 gnt[1] = 1'b1;
  end

  assign r0_ready = gnt[0];
  assign r1_ready = gnt[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr    <= 1'b0;
      p_vin <= 1'b0;
      p_tin <= DEC;
      p_din <= '0;
    end else begin
      p_vin <= |gnt;
      if (|gnt) begin
        rr    <= ~gnt[1];
        p_tin <= req[gnt[1]].typ;
        p_din <= req[gnt[1]].data;
      end
    end
  end

  // Tag delay line; entry LAT lines up with the pipeline output of the same block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k <= LAT; k++) tag[k] <= '0;
    end else begin
      tag[0] <= '{v: |gnt, id: gnt[1]};
      for (int unsigned k = 1; k <= LAT; k++) tag[k] <= tag[k-1];
    end
  end

  assign aligned = tag[LAT];

  always_comb begin
    dec = '0;
    if (aligned.v) dec[aligned.id] = 1'b1;
  end

  assign wr = dec & {PORTS{p_vout}};

  // A tagged slot always releases its credit, even if the pipeline dropped the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < PORTS; i++) infl[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < PORTS; i++) begin
        if (gnt[i] && !dec[i])      infl[i] <= infl[i] + (AW+1)'(1);
        else if (!gnt[i] && dec[i]) infl[i] <= infl[i] - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= err | (p_vout != aligned.v);
  end

  sched_resp_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo0 (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (wr[0]),
    .wdata (res),
    .ready (qr[0]),
    .valid (qv[0]),
    .rdata (head[0]),
    .count (cnt[0])
  );

  sched_resp_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo1 (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (wr[1]),
    .wdata (res),
    .ready (qr[1]),
    .valid (qv[1]),
    .rdata (head[1]),
    .count (cnt[1])
  );

  assign q0_valid = qv[0];
  assign q0_type  = head[0].typ;
  assign q0_data  = head[0].data;
  assign q1_valid = qv[1];
  assign q1_type  = head[1].typ;
  assign q1_data  = head[1].data;

endmodule

// File: tb/tb_aes_pipe_sched.sv
// Bench for aes_pipe_sched with a loopback pipeline stub and per-port scoreboards.
module tb_aes_pipe_sched;
  import aes_sched_pkg::*;

  localparam int unsigned LAT   = 10;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic         clk;
  logic         rst_n;
  logic         r0_valid, r0_ready, r0_type;
  logic [127:0] r0_data;
  logic         r1_valid, r1_ready, r1_type;
  logic [127:0] r1_data;
  logic         p_vin, p_tin, p_vout, p_tout;
  logic [127:0] p_din, p_dout;
  logic         q0_valid, q0_ready, q0_type;
  logic [127:0] q0_data;
  logic         q1_valid, q1_ready, q1_type;
  logic [127:0] q1_data;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int viol     = 0;

  logic [128:0] sent0[$], sent1[$], pop0[$], pop1[$];
  int           acc_c0[$], acc_c1[$], pop_c0[$], pop_c1[$], grants[$];
  bit           en0, en1, seq0mode;
  int           lim0, lim1;

  // Loopback pipeline: LAT stages, plus an injection port for stray outputs.
  logic         pv [LAT];
  logic         pt [LAT];
  logic [127:0] pd [LAT];
  logic         inj_v;
  logic [127:0] inj_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LAT; k++) begin
        pv[k] <= 1'b0; pt[k] <= 1'b0; pd[k] <= '0;
      end
    end else begin
      pv[0] <= p_vin; pt[0] <= p_tin; pd[0] <= p_din;
      for (int k = 1; k < LAT; k++) begin
        pv[k] <= pv[k-1]; pt[k] <= pt[k-1]; pd[k] <= pd[k-1];
      end
    end
  end

  assign p_vout = pv[LAT-1] | inj_v;
  assign p_tout = inj_v ? 1'b0 : pt[LAT-1];
  assign p_dout = inj_v ? inj_d : pd[LAT-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  aes_pipe_sched #(.LAT(LAT), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_type(r0_type), .r0_data(r0_data),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_type(r1_type), .r1_data(r1_data),
    .p_vin(p_vin), .p_tin(p_tin), .p_din(p_din),
    .p_vout(p_vout), .p_tout(p_tout), .p_dout(p_dout),
    .q0_valid(q0_valid), .q0_ready(q0_ready), .q0_type(q0_type), .q0_data(q0_data),
    .q1_valid(q1_valid), .q1_ready(q1_ready), .q1_type(q1_type), .q1_data(q1_data),
    .err(err)
  );

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic clear_logs();
    sent0.delete(); sent1.delete(); pop0.delete(); pop1.delete();
    acc_c0.delete(); acc_c1.delete(); pop_c0.delete(); pop_c1.delete();
    grants.delete();
    viol = 0;
  endtask

  // One clock: record handshakes mid-cycle, then present next stimulus after the edge.
  task automatic cycle();
    bit a0, a1;
    @(negedge clk);
    cyc++;
    a0 = 1'b0;
    a1 = 1'b0;
    if (rst_n) begin
      if ((r0_ready && !r0_valid) || (r1_ready && !r1_valid) || (r0_ready && r1_ready)) viol++;
      a0 = r0_valid && r0_ready;
      a1 = r1_valid && r1_ready;
      if (a0) begin sent0.push_back({r0_type, r0_data}); acc_c0.push_back(cyc); grants.push_back(0); end
      if (a1) begin sent1.push_back({r1_type, r1_data}); acc_c1.push_back(cyc); grants.push_back(1); end
      if (q0_valid && q0_ready) begin pop0.push_back({q0_type, q0_data}); pop_c0.push_back(cyc); end
      if (q1_valid && q1_ready) begin pop1.push_back({q1_type, q1_data}); pop_c1.push_back(cyc); end
    end
    @(posedge clk);
    #1;
    if (a0 || !r0_valid) begin
      r0_type = seq0mode ? ENC : 1'($urandom);
      r0_data = seq0mode ? 128'(sent0.size()) : rnd128();
    end
    if (a1 || !r1_valid) begin
      r1_type = 1'($urandom);
      r1_data = rnd128();
    end
    r0_valid = en0 && (sent0.size() < lim0);
    r1_valid = en1 && (sent1.size() < lim1);
  endtask

  task automatic do_reset();
    en0 = 0; en1 = 0; seq0mode = 0;
    r0_valid = 0; r1_valid = 0; q0_ready = 0; q1_ready = 0; inj_v = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    en0 = 0; en1 = 0; seq0mode = 0; lim0 = 0; lim1 = 0;
    r0_valid = 0; r1_valid = 0; r0_type = 0; r1_type = 0; r0_data = '0; r1_data = '0;
    q0_ready = 0; q1_ready = 0; inj_v = 0; inj_d = '0;
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({p_vin, p_tin, p_din} !== '0) begin
      n_fail++; $display("FAIL reset_pipe_in: got %0h expected 0", {p_vin, p_tin, p_din});
    end
    n_checks++;
    if ({q0_valid, q0_type, q0_data, q1_valid, q1_type, q1_data} !== '0) begin
      n_fail++; $display("FAIL reset_q_out: got q0v=%0b q1v=%0b expected all zero", q0_valid, q1_valid);
    end
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b expected 0", err); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    clear_logs();
    en0 = 1; lim0 = 5;
    for (int b = 0; b < 40 && sent0.size() < 5; b++) cycle();
    n_checks++;
    if (sent0.size() != 5) begin n_fail++; $display("FAIL reset_prefill: got %0d accepts expected 5", sent0.size()); end
    n_checks++;
    if (p_vin !== 1'b1) begin n_fail++; $display("FAIL reset_prefill_issue: got p_vin=%0b expected 1", p_vin); end
    rst_n = 1'b0; en0 = 0; r0_valid = 0;
    #1;
    n_checks++;
    if ({p_vin, p_din} !== '0) begin n_fail++; $display("FAIL reset_midstream_pipe: got %0h expected 0", {p_vin, p_din}); end
    n_checks++;
    if ({q0_valid, err, r0_ready} !== 3'b000) begin
      n_fail++; $display("FAIL reset_midstream_out: got %03b expected 000", {q0_valid, err, r0_ready});
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    q0_ready = 1; q1_ready = 1;
    repeat (20) cycle();
    n_checks++;
    if ({q0_valid, q1_valid, err} !== 3'b000 || pop0.size() != 0) begin
      n_fail++; $display("FAIL reset_discard: got qv0=%0b qv1=%0b err=%0b pops=%0d expected 0 0 0 0",
                         q0_valid, q1_valid, err, pop0.size());
    end
  endtask

  task automatic test_single_stream();
    do_reset(); clear_logs();
    q0_ready = 1; seq0mode = 1; en0 = 1; lim0 = 20;
    for (int b = 0; b < 200 && pop0.size() < 20; b++) cycle();
    n_checks++;
    if (sent0.size() != 20 || pop0.size() != 20) begin
      n_fail++; $display("FAIL stream_counts: got acc=%0d pop=%0d expected 20 20", sent0.size(), pop0.size());
    end
    for (int k = 1; k < acc_c0.size(); k++) begin
      n_checks++;
      if (acc_c0[k] != acc_c0[0] + k) begin
        n_fail++; $display("FAIL stream_ready_gap: accept %0d at cycle %0d expected %0d", k, acc_c0[k], acc_c0[0] + k);
      end
    end
    for (int k = 0; k < pop0.size(); k++) begin
      n_checks++;
      if (pop0[k] !== {1'b1, 128'(k)}) begin
        n_fail++; $display("FAIL stream_data[%0d]: got %0h expected %0h", k, pop0[k], {1'b1, 128'(k)});
      end
    end
    if (pop_c0.size() > 0 && acc_c0.size() > 0) begin
      n_checks++;
      if (pop_c0[0] - acc_c0[0] != int'(LAT) + 2) begin
        n_fail++; $display("FAIL stream_latency: got %0d expected %0d", pop_c0[0] - acc_c0[0], LAT + 2);
      end
    end
    if (pop_c0.size() == 20) begin
      n_checks++;
      if (pop_c0[19] - pop_c0[0] != 19) begin
        n_fail++; $display("FAIL stream_out_rate: got span %0d expected 19", pop_c0[19] - pop_c0[0]);
      end
    end
    n_checks++;
    if (viol != 0) begin n_fail++; $display("FAIL stream_protocol: got %0d violations expected 0", viol); end
    en0 = 0; seq0mode = 0;
  endtask

  task automatic test_contention();
    do_reset(); clear_logs();
    q0_ready = 1; q1_ready = 1; en0 = 1; en1 = 1; lim0 = 15; lim1 = 15;
    for (int b = 0; b < 300 && (pop0.size() < 15 || pop1.size() < 15); b++) cycle();
    n_checks++;
    if (grants.size() != 30 || pop0.size() != 15 || pop1.size() != 15) begin
      n_fail++; $display("FAIL cont_counts: got grants=%0d pop0=%0d pop1=%0d expected 30 15 15",
                         grants.size(), pop0.size(), pop1.size());
    end
    for (int k = 0; k < grants.size(); k++) begin
      n_checks++;
      if (grants[k] != k % 2) begin
        n_fail++; $display("FAIL cont_rr[%0d]: got port %0d expected %0d", k, grants[k], k % 2);
      end
    end
    for (int k = 0; k < pop0.size() && k < sent0.size(); k++) begin
      n_checks++;
      if (pop0[k] !== sent0[k]) begin n_fail++; $display("FAIL cont_q0[%0d]: got %0h expected %0h", k, pop0[k], sent0[k]); end
    end
    for (int k = 0; k < pop1.size() && k < sent1.size(); k++) begin
      n_checks++;
      if (pop1[k] !== sent1[k]) begin n_fail++; $display("FAIL cont_q1[%0d]: got %0h expected %0h", k, pop1[k], sent1[k]); end
    end
    n_checks++;
    if (viol != 0) begin n_fail++; $display("FAIL cont_protocol: got %0d violations expected 0", viol); end
    en0 = 0; en1 = 0;
  endtask

  task automatic test_backpressure();
    do_reset(); clear_logs();
    q0_ready = 1; q1_ready = 0; en0 = 1; en1 = 1; lim0 = 1000; lim1 = 1000;
    cycle();
    repeat (60) cycle();
    en0 = 0; r0_valid = 0;
    n_checks++;
    if (sent1.size() != DEPTH) begin n_fail++; $display("FAIL bp_accepts: got %0d expected %0d", sent1.size(), DEPTH); end
    n_checks++;
    if (sent0.size() != 60 - DEPTH) begin n_fail++; $display("FAIL bp_port0_share: got %0d expected %0d", sent0.size(), 60 - DEPTH); end
    repeat (20) cycle();
    n_checks++;
    if (sent1.size() != DEPTH || r1_ready !== 1'b0 || pop1.size() != 0) begin
      n_fail++; $display("FAIL bp_stall: got acc=%0d ready=%0b pops=%0d expected %0d 0 0",
                         sent1.size(), r1_ready, pop1.size(), DEPTH);
    end
    q1_ready = 1;
    cycle();
    q1_ready = 0;
    repeat (30) cycle();
    n_checks++;
    if (sent1.size() != DEPTH + 1 || pop1.size() != 1) begin
      n_fail++; $display("FAIL bp_one_credit: got acc=%0d pops=%0d expected %0d 1", sent1.size(), pop1.size(), DEPTH + 1);
    end
    en1 = 0; r1_valid = 0; q1_ready = 1;
    for (int b = 0; b < 100 && pop1.size() < sent1.size(); b++) cycle();
    n_checks++;
    if (pop1.size() != sent1.size() || pop0.size() != sent0.size()) begin
      n_fail++; $display("FAIL bp_drain: got pop0=%0d pop1=%0d expected %0d %0d",
                         pop0.size(), pop1.size(), sent0.size(), sent1.size());
    end
    for (int k = 0; k < pop1.size() && k < sent1.size(); k++) begin
      n_checks++;
      if (pop1[k] !== sent1[k]) begin n_fail++; $display("FAIL bp_q1[%0d]: got %0h expected %0h", k, pop1[k], sent1[k]); end
    end
    for (int k = 0; k < pop0.size() && k < sent0.size(); k++) begin
      n_checks++;
      if (pop0[k] !== sent0[k]) begin n_fail++; $display("FAIL bp_q0[%0d]: got %0h expected %0h", k, pop0[k], sent0[k]); end
    end
    n_checks++;
    if (viol != 0) begin n_fail++; $display("FAIL bp_protocol: got %0d violations expected 0", viol); end
  endtask

  task automatic test_simul_rw();
    int a;
    do_reset(); clear_logs();
    q0_ready = 0; en0 = 1; lim0 = 3;
    for (int b = 0; b < 40 && sent0.size() < 3; b++) cycle();
    repeat (20) cycle();
    lim0 = 4;
    for (int b = 0; b < 10 && sent0.size() < 4; b++) cycle();
    en0 = 0; r0_valid = 0;
    n_checks++;
    if (sent0.size() != 4) begin n_fail++; $display("FAIL rw_prefill: got %0d accepts expected 4", sent0.size()); end
    a = (acc_c0.size() == 4) ? acc_c0[3] : cyc;
    for (int b = 0; b < 40 && cyc < a + int'(LAT); b++) cycle();
    q0_ready = 1;
    cycle();
    q0_ready = 0;
    n_checks++;
    if (pop0.size() != 1 || (pop0.size() == 1 && pop0[0] !== sent0[0])) begin
      n_fail++; $display("FAIL rw_first_pop: got %0d pops expected 1 of %0h", pop0.size(), sent0[0]);
    end
    n_checks++;
    if (q0_valid !== 1'b1 || q0_data !== sent0[1][127:0]) begin
      n_fail++; $display("FAIL rw_head: got v=%0b %0h expected 1 %0h", q0_valid, q0_data, sent0[1][127:0]);
    end
    repeat (3) cycle();
    q0_ready = 1;
    repeat (10) cycle();
    n_checks++;
    if (pop0.size() != 4 || q0_valid !== 1'b0) begin
      n_fail++; $display("FAIL rw_count: got %0d pops v=%0b expected 4 0", pop0.size(), q0_valid);
    end
    for (int k = 0; k < pop0.size() && k < sent0.size(); k++) begin
      n_checks++;
      if (pop0[k] !== sent0[k]) begin n_fail++; $display("FAIL rw_order[%0d]: got %0h expected %0h", k, pop0[k], sent0[k]); end
    end
  endtask

  task automatic test_mismatch();
    do_reset(); clear_logs();
    q0_ready = 1; q1_ready = 1;
    repeat (3) cycle();
    inj_d = rnd128();
    inj_v = 1;
    #1;
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL mm_before: got err=%0b expected 0", err); end
    cycle();
    inj_v = 0;
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL mm_set: got err=%0b expected 1", err); end
    repeat (5) cycle();
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL mm_sticky: got err=%0b expected 1", err); end
    n_checks++;
    if (pop0.size() + pop1.size() != 0 || {q0_valid, q1_valid} !== 2'b00) begin
      n_fail++; $display("FAIL mm_no_write: got pops=%0d qv=%02b expected 0 00", pop0.size() + pop1.size(), {q0_valid, q1_valid});
    end
  endtask

  initial begin
    test_reset();
    test_single_stream();
    test_contention();
    test_backpressure();
    test_simul_rw();
    test_mismatch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
